// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: finds full rows on a 10x20 board, optionally flashes them,
// collapses the remaining rows downward and blanks the vacated rows at the top.
// Optional feature macro: LINE_CLEAR_FLASH_EN adds the FLASH state and counter.
// Without it, SCAN feeds COLLAPSE directly and flash_rows is always 0.
module line_clear_ctrl #(
    parameter int FLASH_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [2:0]  lines,
    output logic [4:0]  rd_addr,
    input  logic [9:0]  rd_data,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [9:0]  wr_data,
    output logic [19:0] flash_rows
);

    localparam logic [4:0] LAST_ROW = 5'd19;
    localparam logic [9:0] FULL_ROW = 10'h3FF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN      = 3'd1,
        COLLAPSE  = 3'd2,
        CLEAR_TOP = 3'd3,
        DONE      = 3'd4
`ifdef LINE_CLEAR_FLASH_EN
        ,
        FLASH     = 3'd5
`endif
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  scan_reg, scan_next;
    // One extra bit so stepping below row 0 shows up as a set MSB instead of row 31.
    logic [5:0]  src_reg, src_next;
    logic [5:0]  dst_reg, dst_next;
    logic [19:0] full_mask_reg, full_mask_next;
    logic [2:0]  lines_reg, lines_next;
    logic        wr_int;
    logic        flash_on;

`ifdef LINE_CLEAR_FLASH_EN
    localparam int CNT_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
    logic [CNT_W-1:0] flash_cnt_reg, flash_cnt_next;
`endif

    // Number of set bits in the full-row mask (never more than 4 in practice).
    function automatic logic [2:0] popcount20(input logic [19:0] m);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 20; i++) begin
            c = c + {2'b00, m[i]};
        end
        return c;
    endfunction

    // State and datapath registers; reset abandons any pass in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            scan_reg      <= 5'd0;
            src_reg       <= 6'd0;
            dst_reg       <= 6'd0;
            full_mask_reg <= 20'd0;
            lines_reg     <= 3'd0;
`ifdef LINE_CLEAR_FLASH_EN
            flash_cnt_reg <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            scan_reg      <= scan_next;
            src_reg       <= src_next;
            dst_reg       <= dst_next;
            full_mask_reg <= full_mask_next;
            lines_reg     <= lines_next;
`ifdef LINE_CLEAR_FLASH_EN
            flash_cnt_reg <= flash_cnt_next;
`endif
        end
    end

    // Next-state logic plus the board read/write port driven from the current state.
    always_comb begin
        state_next     = state_reg;
        scan_next      = scan_reg;
        src_next       = src_reg;
        dst_next       = dst_reg;
        full_mask_next = full_mask_reg;
        lines_next     = lines_reg;
`ifdef LINE_CLEAR_FLASH_EN
        flash_cnt_next = flash_cnt_reg;
`endif
        rd_addr        = 5'd0;
        wr_int         = 1'b0;
        wr_addr        = 5'd0;
        wr_data        = 10'h000;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = SCAN;
                    scan_next      = 5'd0;
                    full_mask_next = 20'd0;
                end
            end

            SCAN: begin
                rd_addr = scan_reg;
                if (rd_data == FULL_ROW) begin
                    full_mask_next[scan_reg] = 1'b1;
                end
                if (scan_reg == LAST_ROW) begin
                    src_next = 6'd19;
                    dst_next = 6'd19;
                    if (full_mask_next != 20'd0) begin
`ifdef LINE_CLEAR_FLASH_EN
                        state_next     = FLASH;
                        flash_cnt_next = '0;
`else
                        state_next     = COLLAPSE;
`endif
                    end else begin
                        state_next = DONE;
                        lines_next = 3'd0;
                    end
                end else begin
                    scan_next = scan_reg + 5'd1;
                end
            end

`ifdef LINE_CLEAR_FLASH_EN
            FLASH: begin
                if (flash_cnt_reg == FLASH_LAST) begin
                    state_next = COLLAPSE;
                end else begin
                    flash_cnt_next = flash_cnt_reg + 1'b1;
                end
            end
`endif

            COLLAPSE: begin
                rd_addr = src_reg[4:0];
                if (full_mask_reg[src_reg[4:0]]) begin
                    // Full row: drop it by not copying it anywhere.
                    src_next = src_reg - 6'd1;
                end else if (src_reg != dst_reg) begin
                    wr_int   = ~dst_reg[5];
                    wr_addr  = dst_reg[4:0];
                    wr_data  = rd_data;
                    src_next = src_reg - 6'd1;
                    dst_next = dst_reg - 6'd1;
                end else begin
                    // Nothing below has been removed yet, the row stays in place.
                    src_next = src_reg - 6'd1;
                    dst_next = dst_reg - 6'd1;
                end
                if (src_reg == 6'd0) begin
                    state_next = CLEAR_TOP;
                end
            end

            CLEAR_TOP: begin
                if (!dst_reg[5]) begin
                    wr_int  = 1'b1;
                    wr_addr = dst_reg[4:0];
                end
                dst_next = dst_reg - 6'd1;
                if (dst_reg == 6'd0 || dst_reg[5]) begin
                    state_next = DONE;
                    lines_next = popcount20(full_mask_reg);
                end
            end

            DONE: begin
                full_mask_next = 20'd0;
                state_next     = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A write coinciding with reset is suppressed so an aborted pass stops immediately.
    assign wr_en = wr_int & ~rst;
    assign busy  = (state_reg != IDLE);
    assign done  = (state_reg == DONE);
    assign lines = lines_reg;

`ifdef LINE_CLEAR_FLASH_EN
    assign flash_on = (state_reg == FLASH);
`else
    assign flash_on = 1'b0;
`endif

    // Per-row flash enable: only rows marked full, and only while flashing.
    generate
        for (genvar gi = 0; gi < 20; gi++) begin : g_flash
            assign flash_rows[gi] = flash_on & full_mask_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl with a behavioural 20-row board memory.
// Expectations follow the LINE_CLEAR_FLASH_EN setting of the build.
module tb_line_clear_ctrl;

`ifdef LINE_CLEAR_FLASH_EN
    localparam int F_EXP = 4;
`else
    localparam int F_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  lines;
    logic [4:0]  rd_addr;
    logic [9:0]  rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [9:0]  wr_data;
    logic [19:0] flash_rows;

    logic [9:0]  board    [20];
    logic [9:0]  load_img [20];
    logic        load_req;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    line_clear_ctrl #(.FLASH_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .lines      (lines),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .flash_rows (flash_rows)
    );

    // Board memory: whole-image preload or single-row writes from the DUT.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 20; i++) board[i] <= load_img[i];
        end else if (wr_en && wr_addr < 5'd20) begin
            board[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (rd_addr < 5'd20) ? board[rd_addr] : 10'h000;

    function automatic logic [9:0] pat(input int r);
        return 10'h140 | 10'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_board();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 20; i++) load_img[i] = 10'h000;
    endtask

    // One clear pass: start in cycle 0, observe until done, then 5 idle cycles.
    task automatic run_pass(input string name, input int repulse, input int thr,
                            input logic [19:0] fmask, output int lat,
                            output int lines_at_done, output int nwr, output int nwr_top,
                            output int nflash_ok, output int nflash_any,
                            output int extra_done, output int extra_busy);
        int cyc;
        cyc = 0; nwr = 0; nwr_top = 0; nflash_ok = 0; nflash_any = 0;
        extra_done = 0; extra_busy = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 400) begin
            if (wr_en === 1'b1) begin
                nwr++;
                if (int'(wr_addr) < thr) nwr_top++;
            end
            if (fmask != 20'd0 && flash_rows === fmask) nflash_ok++;
            if (flash_rows !== 20'd0) nflash_any++;
            start = (cyc == repulse);
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        lat = cyc;
        lines_at_done = int'(lines);
        if (wr_en === 1'b1) nwr++;
        start = (cyc == repulse);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) extra_done++;
            if (busy === 1'b1) extra_busy++;
        end
        $display("pass %s: latency=%0d lines=%0d writes=%0d flash_cycles=%0d",
                 name, lat, lines_at_done, nwr, nflash_any);
    endtask

    int lat, lns, nwr, nwr_top, nfok, nfany, xdone, xbusy;
    logic [9:0] e;

    initial begin
        rst = 1'b1; start = 1'b0; load_req = 1'b0;
        clear_img();
        load_board();
        @(posedge clk); #1;
        // Reset state
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_lines", 32'(lines), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_flash", 32'(flash_rows), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Empty board
        run_pass("empty", -1, 0, 20'd0, lat, lns, nwr, nwr_top, nfok, nfany, xdone, xbusy);
        check("empty_latency", 32'(lat), 32'd21);
        check("empty_lines", 32'(lns), 32'd0);
        check("empty_writes", 32'(nwr), 32'd0);
        check("empty_flash", 32'(nfany), 32'd0);
        check("empty_done_once", 32'(xdone), 32'd0);

        // Row 19 full, row 18 = 001
        clear_img();
        load_img[19] = 10'h3FF; load_img[18] = 10'h001;
        load_board();
        run_pass("one_row", -1, 1, 20'h80000, lat, lns, nwr, nwr_top, nfok, nfany, xdone, xbusy);
        check("one_latency", 32'(lat), 32'(21 + F_EXP + 21));
        check("one_lines", 32'(lns), 32'd1);
        check("one_writes", 32'(nwr), 32'd20);
        check("one_top_writes", 32'(nwr_top), 32'd1);
        check("one_flash_ok", 32'(nfok), 32'(F_EXP));
        check("one_flash_any", 32'(nfany), 32'(F_EXP));
        check("one_row19", 32'(board[19]), 32'h001);
        check("one_row18", 32'(board[18]), 32'h000);
        check("one_row0", 32'(board[0]), 32'h000);

        // Rows 16-19 full, rows 12-15 = 155
        clear_img();
        for (int r = 16; r < 20; r++) load_img[r] = 10'h3FF;
        for (int r = 12; r < 16; r++) load_img[r] = 10'h155;
        load_board();
        run_pass("four_rows", -1, 4, 20'hF0000, lat, lns, nwr, nwr_top, nfok, nfany, xdone, xbusy);
        check("four_latency", 32'(lat), 32'(21 + F_EXP + 24));
        check("four_lines", 32'(lns), 32'd4);
        check("four_top_writes", 32'(nwr_top), 32'd4);
        check("four_flash_ok", 32'(nfok), 32'(F_EXP));
        for (int r = 0; r < 20; r++) begin
            e = (r >= 16) ? 10'h155 : 10'h000;
            check($sformatf("four_row%0d", r), 32'(board[r]), 32'(e));
        end

        // Non-adjacent full rows 10 and 19
        for (int r = 0; r < 20; r++) load_img[r] = pat(r);
        load_img[10] = 10'h3FF; load_img[19] = 10'h3FF;
        load_board();
        run_pass("split_rows", -1, 2, 20'h80400, lat, lns, nwr, nwr_top, nfok, nfany, xdone, xbusy);
        check("split_latency", 32'(lat), 32'(21 + F_EXP + 22));
        check("split_lines", 32'(lns), 32'd2);
        check("split_top_writes", 32'(nwr_top), 32'd2);
        for (int r = 0; r < 20; r++) begin
            if (r >= 12)     e = pat(r - 1);
            else if (r >= 2) e = pat(r - 2);
            else             e = 10'h000;
            check($sformatf("split_row%0d", r), 32'(board[r]), 32'(e));
        end

        // Only the top row full: rows stay in place, single blanking write
        for (int r = 0; r < 20; r++) load_img[r] = pat(r);
        load_img[0] = 10'h3FF;
        load_board();
        run_pass("top_row", -1, 1, 20'h00001, lat, lns, nwr, nwr_top, nfok, nfany, xdone, xbusy);
        check("top_latency", 32'(lat), 32'(21 + F_EXP + 21));
        check("top_lines", 32'(lns), 32'd1);
        check("top_writes", 32'(nwr), 32'd1);
        check("top_row0", 32'(board[0]), 32'h000);
        check("top_row1", 32'(board[1]), 32'(pat(1)));
        check("top_row19", 32'(board[19]), 32'(pat(19)));

        // Reset in the middle of COLLAPSE
        for (int r = 0; r < 19; r++) load_img[r] = 10'h2AA;
        load_img[19] = 10'h3FF;
        load_board();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21 + F_EXP + 4) begin
            @(posedge clk); #1;
        end
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_wr_gated", 32'(wr_en), 32'd0);
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wr_en", 32'(wr_en), 32'd0);
        check("abort_flash", 32'(flash_rows), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_lines", 32'(lines), 32'd0);
        rst = 1'b0;
        run_pass("after_abort", -1, 0, 20'd0, lat, lns, nwr, nwr_top, nfok, nfany, xdone, xbusy);
        check("abort_rerun_latency", 32'(lat), 32'd21);
        check("abort_rerun_writes", 32'(nwr), 32'd0);
        check("abort_row19", 32'(board[19]), 32'h2AA);
        check("abort_row0", 32'(board[0]), 32'h2AA);

        // Start re-pulsed while busy, and during the DONE cycle
        clear_img();
        load_board();
        run_pass("repulse_scan", 10, 0, 20'd0, lat, lns, nwr, nwr_top, nfok, nfany, xdone, xbusy);
        check("repulse_scan_latency", 32'(lat), 32'd21);
        check("repulse_scan_done_once", 32'(xdone), 32'd0);
        run_pass("repulse_done", 21, 0, 20'd0, lat, lns, nwr, nwr_top, nfok, nfany, xdone, xbusy);
        check("repulse_done_latency", 32'(lat), 32'd21);
        check("repulse_done_idle", 32'(xbusy), 32'd0);
        clear_img();
        load_img[19] = 10'h3FF;
        load_board();
        run_pass("repulse_collapse", 23 + F_EXP, 1, 20'h80000, lat, lns, nwr, nwr_top, nfok, nfany, xdone, xbusy);
        check("repulse_col_latency", 32'(lat), 32'(21 + F_EXP + 21));
        check("repulse_col_done_once", 32'(xdone), 32'd0);
        check("repulse_col_lines", 32'(lns), 32'd1);
        check("repulse_col_flash_any", 32'(nfany), 32'(F_EXP));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
